adder_pipe: RTL
===============

ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width in bits (>=2).
REQ-002 SHALL have parameter STAGES, default 2, number of carry-split pipeline stages (1..WIDTH); WIDTH % STAGES != 0 SHALL be an elaboration error.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operand beat present.
REQ-006 Port: in_ready  output  1  block can accept a beat this cycle.
REQ-007 Port: x, y  input  WIDTH each  operands.
REQ-008 Port: carry_in  input  1  carry into bit 0.
REQ-009 Port: op  input  1  0 = add, 1 = subtract.
REQ-010 Port: out_valid  output  1  result beat present.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: sum  output  WIDTH  result bits.
REQ-013 Port: carry_out  output  1  carry out of MSB (overflow flag when saturation is enabled).

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-015 op=0 SHALL compute x + y + carry_in; op=1 SHALL compute x + ~y + carry_in, so op=1, carry_in=1 gives x - y.
REQ-016 Result SHALL be WIDTH+1 bits: {carry_out, sum}; arithmetic unsigned, modulo 2^(WIDTH+1).
REQ-017 Operands, op and carry_in SHALL be registered on input transfer (stage 0), as in the single-stage adder.
REQ-018 Chunk k (WIDTH/STAGES bits, LSB chunk first) SHALL be summed in stage k+1 using the carry registered from stage k; unused upper operand chunks SHALL be carried forward in registers.
REQ-019 Latency SHALL be exactly STAGES+1 cycles from input transfer to out_valid, with out_ready held high.
REQ-020 With out_ready held high the block SHALL accept one beat per cycle (full throughput, in_ready=1).
REQ-021 Stall: when out_valid && !out_ready the entire pipeline SHALL hold; in_ready SHALL be 0 that cycle; no beat lost or duplicated.
REQ-022 Bubbles SHALL propagate as invalid slots; in_ready SHALL equal !(out_valid && !out_ready) (combinational on out_ready).
REQ-023 sum, carry_out SHALL hold stable while out_valid && !out_ready.
REQ-024 Beats SHALL exit in acceptance order, each carrying its own op/carry_in.

Reset
REQ-025 rst high at a clock edge SHALL clear all stage valid bits; out_valid=0, sum=0, carry_out=0 next cycle.
REQ-026 rst SHALL override a simultaneous input transfer; the in-flight and incoming beats SHALL be discarded.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro ADDER_PIPE_SAT_EN defined: final stage SHALL clamp sum to all-ones when add result overflows (carry_out=1) and to zero when subtract underflows (op=1, carry_out=0); carry_out reports the raw carry.
REQ-029 Macro ADDER_PIPE_SAT_EN undefined: sum SHALL be the raw modulo result, no clamp logic present.

Verification
REQ-030 WIDTH=8, STAGES=2, out_ready=1: x=0xFF, y=0x01, carry_in=0, op=0 -> out_valid after 3 cycles, sum=0x00, carry_out=1 (sum=0xFF with SAT_EN).
REQ-031 op=1, carry_in=1, x=0x05, y=0x07 -> sum=0xFE, carry_out=0 (sum=0x00 with SAT_EN).
REQ-032 Back-to-back 16 random beats, out_ready=1 -> 16 results in order, one per cycle, matching reference model.
REQ-033 out_ready=0 for 5 cycles mid-stream -> in_ready=0 while out_valid, output held stable, no loss/duplication after release.
REQ-034 rst asserted with 2 beats in flight and in_valid=1 -> next cycle out_valid=0, sum=0, carry_out=0; no stale beat emerges later.
REQ-035 Sweep STAGES in {1,2,4,8} at WIDTH=8 and WIDTH=32/STAGES=4 -> latency STAGES+1 and exact results.

Source files
------------

// File: rtl/adder_pipe.sv
// ---------------------------------------------------------------------------
// adder_pipe
//
// Pipelined add/subtract unit with a valid/ready handshake on both sides.
// The WIDTH-bit operands are split into STAGES equal chunks. The LSB chunk is
// summed first, and each later stage sums the next chunk using the carry
// registered by the stage before it. Operands, op and carry_in are captured
// in stage 0. The result is therefore visible STAGES+1 cycles after the input
// transfer.
//
// Parameters:
//   WIDTH   operand / sum width in bits (>= 2)
//   STAGES  number of carry-split stages (1..WIDTH, must divide WIDTH)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (clears every stage)
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle (low only while stalled)
//   x, y       operands
//   carry_in   carry into bit 0
//   op         0 = x + y + carry_in, 1 = x + ~y + carry_in
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        result bits
//   carry_out  carry out of the MSB
//
// Optional feature:
//   ADDER_PIPE_SAT_EN  when defined, the final stage clamps sum to all-ones
//                      on add overflow and to zero on subtract underflow.
//                      carry_out still reports the raw carry.
// ---------------------------------------------------------------------------
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = WIDTH / STAGES;

    // Reject configurations that cannot be split into equal chunks.
    generate
        if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("adder_pipe: WIDTH must be >= 2 and divisible by STAGES (1..WIDTH)");
        end
    endgenerate

    // Stage s holds the operands still needed by the stages after it.
    // Stage STAGES needs no operands, so these arrays stop one stage short.
    logic [WIDTH-1:0] a_q     [0:STAGES-1];
    logic [WIDTH-1:0] b_q     [0:STAGES-1];
    logic [WIDTH-1:0] sum_q   [0:STAGES];
    logic             carry_q [0:STAGES];
    logic             valid_q [0:STAGES];
`ifdef ADDER_PIPE_SAT_EN
    logic             op_q    [0:STAGES-1];
`endif

    logic [WIDTH-1:0] sum_n   [1:STAGES];
    logic             carry_n [1:STAGES];
    logic [CW:0]      chunk;
    logic             advance;

    // A stalled output freezes the whole pipeline, so the upstream handshake
    // follows out_ready combinationally.
    assign advance   = !(valid_q[STAGES] && !out_ready);
    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES];
    assign sum       = sum_q[STAGES];
    assign carry_out = carry_q[STAGES];

    // Stage s adds chunk s-1 on top of the partial sum from stage s-1.
    // It uses the carry that stage s-1 registered.
    // The final stage may also saturate the assembled result.
    always_comb begin
        chunk = '0;
        for (int s = 1; s <= STAGES; s++) begin
            chunk = {1'b0, a_q[s-1][(s-1)*CW +: CW]}
                  + {1'b0, b_q[s-1][(s-1)*CW +: CW]}
                  + {{CW{1'b0}}, carry_q[s-1]};
            sum_n[s]                  = sum_q[s-1];
            sum_n[s][(s-1)*CW +: CW]  = chunk[CW-1:0];
            carry_n[s]                = chunk[CW];
        end
`ifdef ADDER_PIPE_SAT_EN
        if (!op_q[STAGES-1] && carry_n[STAGES]) begin
            sum_n[STAGES] = '1;
        end else if (op_q[STAGES-1] && !carry_n[STAGES]) begin
            sum_n[STAGES] = '0;
        end
`endif
    end

    // Pipeline registers. Reset wipes every slot, which also discards any beat
    // presented on the same edge. Otherwise, all stages move together whenever
    // the output is not stalled, and empty slots travel through as bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= STAGES; s++) begin
                valid_q[s] <= 1'b0;
                sum_q[s]   <= '0;
                carry_q[s] <= 1'b0;
            end
            for (int s = 0; s < STAGES; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
`ifdef ADDER_PIPE_SAT_EN
                op_q[s] <= 1'b0;
`endif
            end
        end else if (advance) begin
            valid_q[0] <= in_valid;
            a_q[0]     <= x;
            b_q[0]     <= op ? ~y : y;
            carry_q[0] <= carry_in;
            sum_q[0]   <= '0;
`ifdef ADDER_PIPE_SAT_EN
            op_q[0]    <= op;
`endif
            for (int s = 1; s <= STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                sum_q[s]   <= sum_n[s];
                carry_q[s] <= carry_n[s];
            end
            for (int s = 1; s < STAGES; s++) begin
                a_q[s] <= a_q[s-1];
                b_q[s] <= b_q[s-1];
`ifdef ADDER_PIPE_SAT_EN
                op_q[s] <= op_q[s-1];
`endif
            end
        end
    end

endmodule
